// File: rtl/stage_ctrl.sv
// stage_ctrl -- game flow controller for a three-stage find-the-keys game.
//
// Ports
//   clk        : system clock; all state changes on its rising edge
//   rst        : synchronous, active-high reset (highest priority)
//   click      : one-cycle pulse, player selection at (click_x, click_y)
//   click_x    : selection x, half resolution (0..319)
//   click_y    : selection y, half resolution (0..239)
//   staff_btn  : one-cycle pulse, opens credits from TITLE
//   state      : TITLE=0 STAFF=1 STAGE1=2 SUCCESS1=3 STAGE2=4 SUCCESS2=5
//                STAGE3=6 SUCCESS3=7 FAIL=8
//   key_find   : keys found in the current stage (0..2)
//   isDark     : room light off (STAGE2 only)
//   time_left  : seconds remaining in the current stage
//
// Build option
//   STAGE_TIMER_EN : when defined, each stage counts down from STAGE_SECONDS
//                    and expiry moves to FAIL. When undefined there is no
//                    tick counter, time_left is constant 0 and FAIL is
//                    unreachable.
module stage_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 25000000,
  parameter int unsigned STAGE_SECONDS = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       click,
  input  logic [8:0] click_x,
  input  logic [8:0] click_y,
  input  logic       staff_btn,
  output logic [3:0] state,
  output logic [1:0] key_find,
  output logic       isDark,
  output logic [7:0] time_left
);

  if (TICKS_PER_SEC < 1 || STAGE_SECONDS < 1 || STAGE_SECONDS > 255) begin : g_bad_params
    $error("stage_ctrl: TICKS_PER_SEC must be >= 1 and STAGE_SECONDS in 1..255");
  end

  typedef enum logic [3:0] {
    S_TITLE    = 4'd0,
    S_STAFF    = 4'd1,
    S_STAGE1   = 4'd2,
    S_SUCCESS1 = 4'd3,
    S_STAGE2   = 4'd4,
    S_SUCCESS2 = 4'd5,
    S_STAGE3   = 4'd6,
    S_SUCCESS3 = 4'd7,
    S_FAIL     = 4'd8
  } state_e;

  // Hit boxes are 20x20, inclusive low corner, exclusive high corner.
  localparam int unsigned BOX     = 20;
  localparam int unsigned KEY0_X  = 65;
  localparam int unsigned KEY0_Y  = 35;
  localparam int unsigned KEY1_X  = 230;
  localparam int unsigned KEY1_Y  = 35;
  localparam int unsigned KEY2_X  = 230;
  localparam int unsigned KEY2_Y  = 205;
  localparam int unsigned LIGHT_X = 180;
  localparam int unsigned LIGHT_Y = 135;

  function automatic logic in_box(input logic [8:0] x, input logic [8:0] y,
                                  input int unsigned x0, input int unsigned y0);
    return (x >= 9'(x0)) && (x < 9'(x0 + BOX)) &&
           (y >= 9'(y0)) && (y < 9'(y0 + BOX));
  endfunction

  state_e     state_q, state_d;
  logic [1:0] key_find_q, key_find_d;
  logic       is_dark_q, is_dark_d;
  logic       in_stage;
  logic       enter_stage;
  logic       key_hit;
  logic       light_hit;

  assign in_stage  = (state_q == S_STAGE1) || (state_q == S_STAGE2) || (state_q == S_STAGE3);
  assign light_hit = in_box(click_x, click_y, LIGHT_X, LIGHT_Y);

  // Only the key matching the current progress counts.
  always_comb begin
    key_hit = 1'b0;
    case (key_find_q)
      2'd0:    key_hit = in_box(click_x, click_y, KEY0_X, KEY0_Y);
      2'd1:    key_hit = in_box(click_x, click_y, KEY1_X, KEY1_Y);
      2'd2:    key_hit = in_box(click_x, click_y, KEY2_X, KEY2_Y);
      default: key_hit = 1'b0;
    endcase
  end

`ifdef STAGE_TIMER_EN
  localparam int unsigned   TICK_W    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);

  logic [TICK_W-1:0] tick_q, tick_d;
  logic [7:0]        time_left_q, time_left_d;
`endif

  always_comb begin
    state_d     = state_q;
    key_find_d  = key_find_q;
    is_dark_d   = is_dark_q;
    enter_stage = 1'b0;

    case (state_q)
      S_TITLE: begin
        if (click) begin
          state_d     = S_STAGE1;
          enter_stage = 1'b1;
        end else if (staff_btn) begin
          state_d = S_STAFF;
        end
      end
      S_STAFF: if (click) state_d = S_TITLE;
      S_STAGE1, S_STAGE2, S_STAGE3: begin
        if (click) begin
          if (state_q == S_STAGE2 && light_hit) begin
            is_dark_d = ~is_dark_q;
          end else if (key_hit && !(state_q == S_STAGE2 && is_dark_q)) begin
            if (key_find_q == 2'd2) begin
              case (state_q)
                S_STAGE1: state_d = S_SUCCESS1;
                S_STAGE2: state_d = S_SUCCESS2;
                default:  state_d = S_SUCCESS3;
              endcase
            end else begin
              key_find_d = key_find_q + 2'd1;
            end
          end
        end
      end
      S_SUCCESS1: begin
        if (click) begin
          state_d     = S_STAGE2;
          enter_stage = 1'b1;
        end
      end
      S_SUCCESS2: begin
        if (click) begin
          state_d     = S_STAGE3;
          enter_stage = 1'b1;
        end
      end
      S_SUCCESS3, S_FAIL: if (click) state_d = S_TITLE;
      default: state_d = S_TITLE;
    endcase

`ifdef STAGE_TIMER_EN
    tick_d      = tick_q;
    time_left_d = time_left_q;
    if (in_stage) begin
      if (tick_q == TICK_LAST) begin
        tick_d      = '0;
        time_left_d = time_left_q - 8'd1;
        // Expiry overrides whatever the click decided this cycle.
        if (time_left_q == 8'd1) state_d = S_FAIL;
      end else begin
        tick_d = tick_q + TICK_W'(1);
      end
    end else begin
      tick_d = '0;
    end
    if (enter_stage) begin
      tick_d      = '0;
      time_left_d = 8'(STAGE_SECONDS);
    end
`endif

    if (enter_stage) begin
      key_find_d = '0;
      is_dark_d  = (state_d == S_STAGE2);
    end
    // Anything that leaves (or is outside) a stage clears the stage flags.
    if (!(state_d == S_STAGE1 || state_d == S_STAGE2 || state_d == S_STAGE3)) begin
      key_find_d = '0;
      is_dark_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_TITLE;
      key_find_q  <= '0;
      is_dark_q   <= 1'b0;
`ifdef STAGE_TIMER_EN
      tick_q      <= '0;
      time_left_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      key_find_q  <= key_find_d;
      is_dark_q   <= is_dark_d;
`ifdef STAGE_TIMER_EN
      tick_q      <= tick_d;
      time_left_q <= time_left_d;
`endif
    end
  end

  assign state    = state_q;
  assign key_find = key_find_q;
  assign isDark   = is_dark_q;
`ifdef STAGE_TIMER_EN
  assign time_left = time_left_q;
`else
  assign time_left = '0;
`endif

endmodule
